// File: rtl/tdes_block_packer_pkg.sv
// tdes_block_packer_pkg: shared TDES ingress constants, FSM states and PKCS#5 pad helper
package tdes_block_packer_pkg;
    localparam int BLK_W = 64;
    localparam int KEY_W = 64;
    localparam int LANES = 8;

    typedef enum logic [1:0] {IDLE, FILL, PADBLK} state_t;

    // m = bytes already used in the final block; m = 0 yields a full pad block of 8s
    function automatic logic [7:0] pkcs5_pad(input logic [3:0] m);
        return 8'(LANES - int'(m));
    endfunction
endpackage

// File: rtl/tdes_block_packer_if.sv
// tdes_block_packer_if: config, byte-stream ingress and block egress of the TDES packer
//   cfg_load/cfg_key1..3 : key latch request
//   in_data/in_valid/in_last/in_ready : byte stream into the packer
//   out_data/out_key1..3/out_valid/out_last/out_ready : block stream to the pipeline
interface tdes_block_packer_if;
    import tdes_block_packer_pkg::*;
    logic             cfg_load;
    logic [KEY_W-1:0] cfg_key1, cfg_key2, cfg_key3;
    logic [7:0]       in_data;
    logic             in_valid, in_last, in_ready;
    logic [BLK_W-1:0] out_data;
    logic [KEY_W-1:0] out_key1, out_key2, out_key3;
    logic             out_valid, out_last, out_ready;

    modport slave (
        input  cfg_load, cfg_key1, cfg_key2, cfg_key3, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_key1, out_key2, out_key3, out_valid, out_last
    );
    modport master (
        output cfg_load, cfg_key1, cfg_key2, cfg_key3, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_key1, out_key2, out_key3, out_valid, out_last
    );
endinterface

// File: rtl/tdes_byte_accum.sv
// tdes_byte_accum: 8-lane byte accumulator with lane counter and final-block pad fill
//   clr/push/last/data : counter clear, accepted byte, final-byte flag, byte value
//   blk  : block formed from held lanes, the current byte and pad fill above it
//   full : current byte lands in the last lane
module tdes_byte_accum
    import tdes_block_packer_pkg::*;
#(
    parameter bit PAD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             last,
    input  logic [7:0]       data,
    output logic [BLK_W-1:0] blk,
    output logic             full
);
    logic [7:0] acc [LANES];
    logic [2:0] n;
    logic [7:0] fill;

    // lanes above the current byte only matter when it is the final byte,
    // so they always carry the pad value for a message ending here
    always_comb begin
        full = n == 3'd7;
        fill = PAD_EN ? pkcs5_pad({1'b0, n} + 4'd1) : 8'h00;
        for (int i = 0; i < LANES; i++)
            blk[BLK_W-1-8*i -: 8] = i < int'(n) ? acc[i] : i == int'(n) ? data : fill;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst)
            n <= 3'd0;
        else if (clr)
            n <= 3'd0;
        else if (push)
            n <= (full || last) ? 3'd0 : n + 3'd1;

    always_ff @(posedge clk)
        if (push)
            acc[n] <= data;
endmodule

// File: rtl/tdes_block_packer.sv
// tdes_block_packer: packs a byte stream into 64-bit TDES blocks with PKCS#5 padding and per-message keys
//   clk/rst : clock, asynchronous active-high reset
//   bus     : slave side of tdes_block_packer_if (config, byte ingress, block egress)
module tdes_block_packer
    import tdes_block_packer_pkg::*;
#(
    parameter bit PAD_EN = 1'b1
) (
    input logic               clk,
    input logic               rst,
    tdes_block_packer_if.slave bus
);
    state_t           state;
    logic [KEY_W-1:0] k1, k2, k3;
    logic [BLK_W-1:0] blk, nxt_data;
    logic             full, free, push, load, nxt_last;

    tdes_byte_accum #(.PAD_EN(PAD_EN)) u_accum (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE && bus.cfg_load),
        .push (push),
        .last (bus.in_last),
        .data (bus.in_data),
        .blk  (blk),
        .full (full)
    );

    always_comb begin
        free         = !bus.out_valid || bus.out_ready;
        bus.in_ready = state == FILL && free;
        push         = bus.in_valid && bus.in_ready;
        load         = state == PADBLK ? free : push && (bus.in_last || full);
        nxt_data     = state == PADBLK ? {LANES{pkcs5_pad(4'd0)}} : blk;
        // a message ending exactly on a block boundary owes a trailing pad block
        nxt_last     = state == PADBLK || (bus.in_last && !(full && PAD_EN));
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state        <= IDLE;
            k1           <= '0;
            k2           <= '0;
            k3           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last <= 1'b0;
            bus.out_data <= '0;
            bus.out_key1 <= '0;
            bus.out_key2 <= '0;
            bus.out_key3 <= '0;
        end else begin
            if (bus.out_ready)
                bus.out_valid <= 1'b0;
            if (load) begin
                bus.out_valid <= 1'b1;
                bus.out_last <= nxt_last;
                bus.out_data <= nxt_data;
                bus.out_key1 <= k1;
                bus.out_key2 <= k2;
                bus.out_key3 <= k3;
            end
            case (state)
                IDLE: if (bus.cfg_load) begin
                    k1    <= bus.cfg_key1;
                    k2    <= bus.cfg_key2;
                    k3    <= bus.cfg_key3;
                    state <= FILL;
                end
                FILL:    state <= load && bus.in_last ? (full && PAD_EN ? PADBLK : IDLE) : FILL;
                PADBLK:  state <= free ? IDLE : PADBLK;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_tdes_block_packer.sv
// tb_tdes_block_packer: randomized directed bench for tdes_block_packer with PAD_EN = 1 and 0 side by side
module tb_tdes_block_packer;
    import tdes_block_packer_pkg::*;

    typedef logic [7:0] bq_t [$];
    typedef struct packed {
        logic [63:0] d, k1, k2, k3;
        logic        last;
    } blk_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cfg_load = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [63:0] key1 = '0, key2 = '0, key3 = '0;
    logic [7:0]  in_data = '0;
    logic [63:0] ka, kb, kc;
    bit          gaps = 1'b0;
    int          tests = 0, fails = 0;
    blk_t        q1[$], q0[$], exp_q[$];
    bq_t         msg;

    tdes_block_packer_if b1();
    tdes_block_packer_if b0();

    assign b1.cfg_load = cfg_load;
    assign b1.cfg_key1 = key1;
    assign b1.cfg_key2 = key2;
    assign b1.cfg_key3 = key3;
    assign b1.in_data = in_data;
    assign b1.in_valid = in_valid;
    assign b1.in_last = in_last;
    assign b1.out_ready = out_ready;
    assign b0.cfg_load = cfg_load;
    assign b0.cfg_key1 = key1;
    assign b0.cfg_key2 = key2;
    assign b0.cfg_key3 = key3;
    assign b0.in_data = in_data;
    assign b0.in_valid = in_valid;
    assign b0.in_last = in_last;
    assign b0.out_ready = out_ready;

    tdes_block_packer #(.PAD_EN(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    tdes_block_packer #(.PAD_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (b1.out_valid && b1.out_ready)
            q1.push_back({b1.out_data, b1.out_key1, b1.out_key2, b1.out_key3, b1.out_last});
        if (b0.out_valid && b0.out_ready)
            q0.push_back({b0.out_data, b0.out_key1, b0.out_key2, b0.out_key3, b0.out_last});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bq_t rnd(input int n);
        bq_t q;
        repeat (n) q.push_back(8'($urandom));
        return q;
    endfunction

    // Reference: pad the whole message as a byte list, then cut it into 8-byte blocks
    function automatic void model(input bq_t m, input bit pad, input logic [63:0] a, b, c);
        bq_t  p = m;
        int   r = m.size() % 8;
        blk_t x;
        exp_q.delete();
        if (pad) repeat (8 - r) p.push_back(8'(8 - r));
        else if (r != 0) repeat (8 - r) p.push_back(8'h00);
        for (int i = 0; i < p.size(); i += 8) begin
            x.d = '0;
            for (int j = 0; j < 8; j++) x.d = {x.d[55:0], p[i+j]};
            x.k1 = a;
            x.k2 = b;
            x.k3 = c;
            x.last = i + 8 == p.size();
            exp_q.push_back(x);
        end
    endfunction

    task automatic check_blocks(input string tag, input bit pad, input bq_t m, input logic [63:0] a, b, c);
        blk_t g[$];
        g = pad ? q1 : q0;
        model(m, pad, a, b, c);
        chk({tag, "_count"}, 64'(g.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < g.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), g[i].d, exp_q[i].d);
            chk($sformatf("%s_key1_%0d", tag, i), g[i].k1, exp_q[i].k1);
            chk($sformatf("%s_key2_%0d", tag, i), g[i].k2, exp_q[i].k2);
            chk($sformatf("%s_key3_%0d", tag, i), g[i].k3, exp_q[i].k3);
            chk($sformatf("%s_last%0d", tag, i), 64'(g[i].last), 64'(exp_q[i].last));
        end
    endtask

    task automatic load(input logic [63:0] a, b, c);
        key1 = a;
        key2 = b;
        key3 = c;
        cfg_load = 1'b1;
        idle(1);
        cfg_load = 1'b0;
    endtask

    // Idle cycles may carry a stray in_last, which must be ignored without in_valid
    task automatic send(input bq_t m, input bit end_last);
        for (int i = 0; i < m.size(); i++) begin
            int t = 0;
            bit acc = 1'b0;
            while (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_last = 1'($urandom_range(0, 1));
                in_data = 8'($urandom);
                idle(1);
            end
            in_data = m[i];
            in_valid = 1'b1;
            in_last = end_last && i == m.size() - 1;
            do begin
                @(negedge clk);
                acc = b1.in_ready;
                @(posedge clk);
                #1;
                t++;
            end while (!acc && t < 200);
            if (!acc) chk("send_timeout", 64'(acc), 64'd1);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    function automatic void new_keys();
        ka = {$urandom, $urandom};
        kb = {$urandom, $urandom};
        kc = {$urandom, $urandom};
    endfunction

    initial begin
        idle(2);
        chk("rst_out_valid", 64'(b1.out_valid), 64'd0);
        chk("rst_out_last", 64'(b1.out_last), 64'd0);
        chk("rst_out_data", b1.out_data, 64'd0);
        chk("rst_out_key1", b1.out_key1, 64'd0);
        chk("rst_out_key3", b1.out_key3, 64'd0);
        chk("rst_in_ready", 64'(b1.in_ready), 64'd0);
        chk("rst_in_ready_p0", 64'(b0.in_ready), 64'd0);
        rst = 1'b0;
        idle(1);
        chk("idle_in_ready", 64'(b1.in_ready), 64'd0);

        // 16 bytes, boundary-aligned end: pad block follows with PAD_EN = 1
        ka = 64'hA0A1A2A3A4A5A6A7;
        kb = 64'hB0B1B2B3B4B5B6B7;
        kc = 64'hC0C1C2C3C4C5C6C7;
        load(ka, kb, kc);
        msg.delete();
        for (int i = 0; i < 16; i++) msg.push_back(8'(i));
        q1.delete();
        q0.delete();
        send(msg, 1'b1);
        idle(4);
        check_blocks("t1", 1'b1, msg, ka, kb, kc);
        check_blocks("t1p0", 1'b0, msg, ka, kb, kc);

        // short message, registered output one cycle after the last byte
        load(ka, kb, kc);
        msg = '{8'hAA, 8'hBB, 8'hCC};
        q1.delete();
        q0.delete();
        send(msg, 1'b1);
        chk("t2_valid", 64'(b1.out_valid), 64'd1);
        chk("t2_data", b1.out_data, 64'hAABBCC0505050505);
        chk("t2_last", 64'(b1.out_last), 64'd1);
        chk("t3_data", b0.out_data, 64'hAABBCC0000000000);
        chk("t3_last", 64'(b0.out_last), 64'd1);
        idle(1);
        chk("t2_no_extra", 64'(b1.out_valid), 64'd0);
        chk("t3_no_extra", 64'(b0.out_valid), 64'd0);
        idle(2);
        check_blocks("t2", 1'b1, msg, ka, kb, kc);
        check_blocks("t3", 1'b0, msg, ka, kb, kc);

        // backpressure on a pending block
        new_keys();
        load(ka, kb, kc);
        gaps = 1'b1;
        msg = rnd(20);
        q1.delete();
        q0.delete();
        fork
            send(msg, 1'b1);
            begin : bp
                logic [63:0] held;
                int t;
                t = 0;
                idle(3);
                out_ready = 1'b0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!b1.out_valid && t < 200);
                chk("t4_pending", 64'(b1.out_valid), 64'd1);
                held = b1.out_data;
                repeat (5) begin
                    @(negedge clk);
                    chk("t4_hold_data", b1.out_data, held);
                    chk("t4_hold_valid", 64'(b1.out_valid), 64'd1);
                    chk("t4_hold_in_ready", 64'(b1.in_ready), 64'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(4);
        check_blocks("t4", 1'b1, msg, ka, kb, kc);
        check_blocks("t4p0", 1'b0, msg, ka, kb, kc);

        // cfg_load mid-message is ignored; a later message takes the new keys
        new_keys();
        load(ka, kb, kc);
        msg = rnd(12);
        q1.delete();
        q0.delete();
        fork
            send(msg, 1'b1);
            begin
                idle(4);
                key1 = ~ka;
                key2 = ~kb;
                key3 = ~kc;
                cfg_load = 1'b1;
                idle(1);
                cfg_load = 1'b0;
            end
        join
        idle(4);
        check_blocks("t5a", 1'b1, msg, ka, kb, kc);
        load(~ka, ~kb, ~kc);
        msg = rnd(5);
        q1.delete();
        q0.delete();
        send(msg, 1'b1);
        idle(4);
        check_blocks("t5b", 1'b1, msg, ~ka, ~kb, ~kc);
        check_blocks("t5bp0", 1'b0, msg, ~ka, ~kb, ~kc);

        // reset mid-message drops the partial block
        gaps = 1'b0;
        new_keys();
        load(ka, kb, kc);
        q1.delete();
        q0.delete();
        send(rnd(5), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_out_data", b1.out_data, 64'd0);
        chk("t6_out_key2", b1.out_key2, 64'd0);
        chk("t6_out_valid", 64'(b1.out_valid), 64'd0);
        chk("t6_out_last", 64'(b1.out_last), 64'd0);
        chk("t6_in_ready", 64'(b1.in_ready), 64'd0);
        chk("t6_p0_out_data", b0.out_data, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        chk("t6_dropped", 64'(q1.size()), 64'd0);
        new_keys();
        load(ka, kb, kc);
        msg = rnd(8);
        send(msg, 1'b1);
        idle(4);
        check_blocks("t6", 1'b1, msg, ka, kb, kc);
        check_blocks("t6p0", 1'b0, msg, ka, kb, kc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
